pid_multi: RTL and testbench
============================

# pid_multi

Time-multiplexed, multi-channel fixed-point PID controller, the parametrised successor to the single-loop PID block. It sits between the temperature-sensor front end and the heater PWM stage and serves `CHANNELS` independent heater loops with one shared signed multiplier. Each channel keeps its own integral accumulator, previous error and saturation flags. It adds anti-windup, per-channel clear and a start/computed handshake.

## Interface
- `WIDTH`, 12, data width of every signed fixed-point operand and result.
- `FRAC`, 4, fractional bits; default format is Q8.4.
- `CHANNELS`, 2, number of independent loops (≥1).
- `CH_W`, `$clog2(CHANNELS)` (min 1), channel index width.
- `MAX_OUT`, 12'h3F0 (63.0), upper clamp on `response`.
- `MIN_OUT`, 12'h000 (0.0), lower clamp on `response`.
- `INT_MAX`, 12'h200 (32.0), integral clamp; the integral range is ±`INT_MAX`.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `RST_n`  in  1  synchronous active-low reset.
- `start`  in  1  request a computation; accepted only when `busy`=0.
- `clr`  in  1  clear the state of channel `ch`; accepted only when `busy`=0.
- `ch`  in  CH_W  channel index, sampled with `start`/`clr`.
- `kp`, `ki`, `kd`  in  WIDTH each  signed gains, sampled with `start`.
- `Setpoint`  in  WIDTH  signed target, sampled with `start`.
- `measured_value`  in  WIDTH  signed measurement, sampled with `start`.
- `busy`  out  1  high from the accept cycle through the DONE cycle.
- `response`  out  WIDTH  signed, clamped controller output; holds its value between computations.
- `resp_ch`  out  CH_W  channel that `response` belongs to.
- `computed`  out  1  one-cycle pulse; `response` is valid and newly updated.

## Operation
- FSM states: IDLE → ERR → MUL_P → MUL_I → MUL_D → SUM → DONE → IDLE. Each state lasts one cycle.
- IDLE: `start`=1 latches the inputs and moves to ERR.
  - `clr`=1 zeroes the channel's integral, previous error and sat flags in that cycle, and the FSM stays in IDLE.
  - `start` and `clr` together: the clear takes effect first, then the start is accepted.
  - `ch` ≥ `CHANNELS`: the request is ignored.
- ERR:
  - e = Setpoint − measured_value, computed at WIDTH+1 bits and saturated to WIDTH.
  - d = e − prev_err[ch], saturated to WIDTH.
  - Candidate integral i' = integ[ch] + e, saturated to ±`INT_MAX`.
  - Anti-windup: integ[ch] is held if (sat_hi[ch] and e>0) or (sat_lo[ch] and e<0). Otherwise integ[ch] ← i'.
  - prev_err[ch] ← e.
- MUL_P, MUL_I, MUL_D: the shared multiplier forms kp·e, ki·integ[ch] and kd·d in turn.
  - Each product is a 2·WIDTH signed value, arithmetic-shifted right by `FRAC` (truncation toward −∞), then saturated to WIDTH signed.
- SUM:
  - s = P + I + D at WIDTH+2 bits, clamped to [`MIN_OUT`, `MAX_OUT`].
  - sat_hi[ch] = (s > `MAX_OUT`); sat_lo[ch] = (s < `MIN_OUT`).
- DONE: `response` ← clamped s, `resp_ch` ← ch, `computed` = 1, then return to IDLE.
- While `busy`=1, `start` and `clr` are ignored; no queueing.
- Reset (`RST_n`=0 at a rising edge), including mid-computation:
  - FSM goes to IDLE.
  - All per-channel state is cleared.
  - `response`=0, `resp_ch`=0, `computed`=0, `busy`=0.
  - A computation in progress is discarded and produces no `computed` pulse.

## Timing
- If `start` is accepted at edge k, `busy` rises after edge k, `computed` is high for the cycle after edge k+6, and `response` changes at that same edge.
- Fixed latency of 7 cycles from accept to `computed`. Minimum spacing between accepted starts is 7 cycles; `start` is accepted again in the cycle after `computed`.
- `clr` takes effect at the accepting edge; a `start` on the following cycle sees cleared state.
- Gains and operands may change freely after the accept edge.

## Test plan
- kp=0x008 (0.5), ki=kd=0, Setpoint=0x240, measured=0x182, ch 0 → e=0x0BE, `response`=0x05F, `computed` pulse 7 cycles after accept.
- kd=0x008 only, ch 0: first call measured=0x182 → 0x05F; second call measured=0x1C2 → D=−0x020, clamped to 0x000. Then kp=0x080, measured=0x182 → 95.0 clamped to 0x3F0.
- ki=0x008 only, three calls with e=0x0BE → integral 0x0BE, 0x17C, then clamped to 0x200 → responses 0x05F, 0x0BE, 0x100.
- Interleave ch 0 and ch 1 with the integral test on ch 0 only → ch 1 still returns its first-call value; `resp_ch` matches the requesting channel each time.
- Anti-windup: drive ch 0 into the `MAX_OUT` clamp with ki>0 and e>0 → integral frozen on the next call. After `clr`=1 for ch 0, the next start behaves exactly as after reset.
- Assert `start` while `busy`=1 → ignored, exactly one `computed` pulse. Assert `RST_n`=0 during MUL_I → no `computed` pulse, all outputs 0 on the next cycle.

Source files
------------

// File: rtl/pid_multi.sv
// pid_multi: time-multiplexed multi-channel fixed-point PID controller.
// One shared signed multiplier serves all loops. Each channel keeps its own
// integral, previous error and output-saturation flags. A computation walks
// ERR -> MUL_P -> MUL_I -> MUL_D -> SUM -> DONE, one cycle per state.
module pid_multi #(
  parameter int               WIDTH    = 12,
  parameter int               FRAC     = 4,
  parameter int               CHANNELS = 2,
  parameter int               CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter logic [WIDTH-1:0] MAX_OUT  = 12'h3F0,
  parameter logic [WIDTH-1:0] MIN_OUT  = 12'h000,
  parameter logic [WIDTH-1:0] INT_MAX  = 12'h200
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             start,
  input  logic             clr,
  input  logic [CH_W-1:0]  ch,
  input  logic [WIDTH-1:0] kp,
  input  logic [WIDTH-1:0] ki,
  input  logic [WIDTH-1:0] kd,
  input  logic [WIDTH-1:0] Setpoint,
  input  logic [WIDTH-1:0] measured_value,
  output logic             busy,
  output logic [WIDTH-1:0] response,
  output logic [CH_W-1:0]  resp_ch,
  output logic             computed
);

  localparam int PW = 2 * WIDTH;

  // Clamp limits widened to the WIDTH+2 domain of the sum and integral.
  localparam logic signed [WIDTH+1:0] MAX_X = $signed({{2{MAX_OUT[WIDTH-1]}}, MAX_OUT});
  localparam logic signed [WIDTH+1:0] MIN_X = $signed({{2{MIN_OUT[WIDTH-1]}}, MIN_OUT});
  localparam logic signed [WIDTH+1:0] INT_X = $signed({2'b00, INT_MAX});
  localparam logic signed [WIDTH+1:0] INT_NX = -INT_X;

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_MULP, S_MULI, S_MULD, S_SUM, S_DONE
  } state_t;

  // Saturate a WIDTH+1 signed difference to WIDTH.
  function automatic logic signed [WIDTH-1:0] sat_e(input logic signed [WIDTH:0] x);
    if (x[WIDTH] != x[WIDTH-1])
      sat_e = x[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      sat_e = x[WIDTH-1:0];
  endfunction

  // Drop FRAC bits (arithmetic shift, truncation toward -inf), saturate to WIDTH.
  function automatic logic signed [WIDTH-1:0] sat_prod(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] sh;
    logic                 fits;
    sh   = p >>> FRAC;
    fits = (&sh[PW-1:WIDTH-1]) | ~(|sh[PW-1:WIDTH-1]);
    if (!fits)
      sat_prod = sh[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      sat_prod = sh[WIDTH-1:0];
  endfunction

  // Clamp the integral candidate to +/-INT_MAX.
  function automatic logic signed [WIDTH-1:0] clamp_int(input logic signed [WIDTH+1:0] x);
    if (x > INT_X)
      clamp_int = INT_X[WIDTH-1:0];
    else if (x < INT_NX)
      clamp_int = INT_NX[WIDTH-1:0];
    else
      clamp_int = x[WIDTH-1:0];
  endfunction

  // Clamp the P+I+D sum to [MIN_OUT, MAX_OUT].
  function automatic logic signed [WIDTH-1:0] clamp_out(input logic signed [WIDTH+1:0] x);
    if (x > MAX_X)
      clamp_out = MAX_OUT;
    else if (x < MIN_X)
      clamp_out = MIN_OUT;
    else
      clamp_out = x[WIDTH-1:0];
  endfunction

  state_t r_state, w_next;

  // Latched request
  logic [CH_W-1:0]         r_ch;
  logic signed [WIDTH-1:0] r_kp, r_ki, r_kd, r_sp, r_mv;

  // Intermediate terms
  logic signed [WIDTH-1:0] r_e, r_d, r_p, r_i, r_dt, r_s;

  // Per-channel state
  logic signed [WIDTH-1:0] r_integ [CHANNELS];
  logic signed [WIDTH-1:0] r_prev  [CHANNELS];
  logic [CHANNELS-1:0]     r_sat_hi, r_sat_lo;

  logic                    w_ch_ok, w_accept, w_clr_acc, w_hold;
  logic signed [WIDTH:0]   w_e_wide, w_d_wide;
  logic signed [WIDTH-1:0] w_e, w_d, w_icand;
  logic signed [WIDTH+1:0] w_i_wide, w_s_wide;
  logic signed [WIDTH-1:0] w_ma, w_mb;
  logic signed [PW-1:0]    w_prod;

  assign w_ch_ok   = ({1'b0, ch} < (CH_W+1)'(CHANNELS));
  assign w_accept  = (r_state == S_IDLE) && start && w_ch_ok;
  assign w_clr_acc = (r_state == S_IDLE) && clr && w_ch_ok;

  // Error, derivative and integral candidate for the latched channel.
  assign w_e_wide = $signed({r_sp[WIDTH-1], r_sp}) - $signed({r_mv[WIDTH-1], r_mv});
  assign w_e      = sat_e(w_e_wide);
  assign w_d_wide = $signed({w_e[WIDTH-1], w_e}) - $signed({r_prev[r_ch][WIDTH-1], r_prev[r_ch]});
  assign w_d      = sat_e(w_d_wide);
  assign w_i_wide = $signed({{2{r_integ[r_ch][WIDTH-1]}}, r_integ[r_ch]})
                  + $signed({{2{w_e[WIDTH-1]}}, w_e});
  assign w_icand  = clamp_int(w_i_wide);
  // Anti-windup: stop integrating further into a saturated output.
  assign w_hold   = (r_sat_hi[r_ch] && !w_e[WIDTH-1] && (w_e != '0))
                 || (r_sat_lo[r_ch] && w_e[WIDTH-1]);

  assign w_s_wide = $signed({{2{r_p[WIDTH-1]}}, r_p})
                  + $signed({{2{r_i[WIDTH-1]}}, r_i})
                  + $signed({{2{r_dt[WIDTH-1]}}, r_dt});

  // Shared multiplier operand select, one product per MUL state.
  always_comb begin
    w_ma = '0;
    w_mb = '0;
    case (r_state)
      S_MULP: begin w_ma = r_kp; w_mb = r_e;            end
      S_MULI: begin w_ma = r_ki; w_mb = r_integ[r_ch];  end
      S_MULD: begin w_ma = r_kd; w_mb = r_d;            end
      default: ;
    endcase
  end

  assign w_prod = $signed({{WIDTH{w_ma[WIDTH-1]}}, w_ma})
                * $signed({{WIDTH{w_mb[WIDTH-1]}}, w_mb});

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic: fixed walk once a request is accepted.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ERR;
      S_ERR:   w_next = S_MULP;
      S_MULP:  w_next = S_MULI;
      S_MULI:  w_next = S_MULD;
      S_MULD:  w_next = S_SUM;
      S_SUM:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (r_state != S_IDLE);
  end

  // Datapath registers; contents are don't-care outside a computation.
  always_ff @(posedge CLK) begin
    // request capture
    if (w_accept) begin
      r_ch <= ch;
      r_kp <= $signed(kp);
      r_ki <= $signed(ki);
      r_kd <= $signed(kd);
      r_sp <= $signed(Setpoint);
      r_mv <= $signed(measured_value);
    end
    // error stage
    if (r_state == S_ERR) begin
      r_e <= w_e;
      r_d <= w_d;
    end
    // multiply stages
    if (r_state == S_MULP) r_p  <= sat_prod(w_prod);
    if (r_state == S_MULI) r_i  <= sat_prod(w_prod);
    if (r_state == S_MULD) r_dt <= sat_prod(w_prod);
    // sum stage
    if (r_state == S_SUM)  r_s  <= clamp_out(w_s_wide);
  end

  // Per-channel state: clear, integrate/remember error, saturation flags.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_integ[i] <= '0;
        r_prev[i]  <= '0;
      end
      r_sat_hi <= '0;
      r_sat_lo <= '0;
    end else begin
      if (w_clr_acc) begin
        r_integ[ch]  <= '0;
        r_prev[ch]   <= '0;
        r_sat_hi[ch] <= 1'b0;
        r_sat_lo[ch] <= 1'b0;
      end
      if (r_state == S_ERR) begin
        r_prev[r_ch] <= w_e;
        if (!w_hold) r_integ[r_ch] <= w_icand;
      end
      if (r_state == S_SUM) begin
        r_sat_hi[r_ch] <= (w_s_wide > MAX_X);
        r_sat_lo[r_ch] <= (w_s_wide < MIN_X);
      end
    end
  end

  // Result registers: response holds until the next DONE.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      response <= '0;
      resp_ch  <= '0;
      computed <= 1'b0;
    end else begin
      computed <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        response <= r_s;
        resp_ch  <= r_ch;
      end
    end
  end

endmodule

// File: tb/tb_pid_multi.sv
// Directed bench for pid_multi (default parameters, Q8.4, 2 channels).
module tb_pid_multi;

  logic        CLK;
  logic        RST_n;
  logic        start;
  logic        clr;
  logic        ch;
  logic [11:0] kp, ki, kd, sp, mv;
  logic        busy;
  logic [11:0] response;
  logic        resp_ch;
  logic        computed;

  int n_chk  = 0;
  int n_fail = 0;

  pid_multi dut (
    .CLK            (CLK),
    .RST_n          (RST_n),
    .start          (start),
    .clr            (clr),
    .ch             (ch),
    .kp             (kp),
    .ki             (ki),
    .kd             (kd),
    .Setpoint       (sp),
    .measured_value (mv),
    .busy           (busy),
    .response       (response),
    .resp_ch        (resp_ch),
    .computed       (computed)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // clr_mode: 0 none, 1 clear one cycle before start, 2 clear together with start
  typedef struct {
    int          clr_mode;
    logic        ch;
    logic [11:0] kp;
    logic [11:0] ki;
    logic [11:0] kd;
    logic [11:0] sp;
    logic [11:0] mv;
    logic [11:0] exp_resp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Runs one computation starting at a negedge; returns at the negedge where
  // computed is seen (or after a bounded wait), so calls can run back to back.
  task automatic do_call(input int clr_mode, input logic c,
                         input logic [11:0] g_p, input logic [11:0] g_i, input logic [11:0] g_d,
                         input logic [11:0] s, input logic [11:0] m,
                         output logic [11:0] r, output logic rc,
                         output int lat, output logic b1, output logic bdone);
    if (clr_mode == 1) begin
      clr = 1'b1; ch = c;
      @(posedge CLK); @(negedge CLK);
      clr = 1'b0;
    end
    ch = c; kp = g_p; ki = g_i; kd = g_d; sp = s; mv = m;
    clr = (clr_mode == 2);
    start = 1'b1;
    @(posedge CLK); @(negedge CLK);
    start = 1'b0; clr = 1'b0;
    ch = ~c; kp = 12'($urandom); ki = 12'($urandom); kd = 12'($urandom);
    sp = 12'($urandom); mv = 12'($urandom);
    b1 = busy;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      if (computed) begin lat = i; break; end
      @(negedge CLK);
    end
    r = response; rc = resp_ch; bdone = busy;
  endtask

  vec_t        vt [18];
  logic [11:0] r;
  logic        rc, b1, bd;
  int          lat, pulses;
  logic [11:0] cap;

  initial begin
    vt[0]  = '{0, 1'b0, 12'h008, 12'h000, 12'h000, 12'h240, 12'h182, 12'h05F};
    vt[1]  = '{1, 1'b0, 12'h000, 12'h000, 12'h008, 12'h240, 12'h182, 12'h05F};
    vt[2]  = '{0, 1'b0, 12'h000, 12'h000, 12'h008, 12'h240, 12'h1C2, 12'h000};
    vt[3]  = '{0, 1'b0, 12'h080, 12'h000, 12'h000, 12'h240, 12'h182, 12'h3F0};
    vt[4]  = '{1, 1'b0, 12'h000, 12'h008, 12'h000, 12'h240, 12'h182, 12'h05F};
    vt[5]  = '{0, 1'b0, 12'h000, 12'h008, 12'h000, 12'h240, 12'h182, 12'h0BE};
    vt[6]  = '{0, 1'b0, 12'h000, 12'h008, 12'h000, 12'h240, 12'h182, 12'h100};
    vt[7]  = '{2, 1'b0, 12'h000, 12'h008, 12'h000, 12'h240, 12'h182, 12'h05F};
    vt[8]  = '{0, 1'b1, 12'h000, 12'h008, 12'h000, 12'h240, 12'h182, 12'h05F};
    vt[9]  = '{0, 1'b0, 12'h000, 12'h008, 12'h000, 12'h240, 12'h182, 12'h0BE};
    vt[10] = '{0, 1'b1, 12'h000, 12'h008, 12'h000, 12'h240, 12'h182, 12'h0BE};
    vt[11] = '{1, 1'b0, 12'h080, 12'h008, 12'h000, 12'h240, 12'h182, 12'h3F0};
    vt[12] = '{0, 1'b0, 12'h080, 12'h008, 12'h000, 12'h240, 12'h182, 12'h3F0};
    vt[13] = '{0, 1'b0, 12'h000, 12'h008, 12'h000, 12'h240, 12'h182, 12'h05F};
    vt[14] = '{0, 1'b0, 12'h000, 12'h008, 12'h000, 12'h240, 12'h182, 12'h0BE};
    vt[15] = '{2, 1'b0, 12'h000, 12'h008, 12'h008, 12'h240, 12'h182, 12'h0BE};
    vt[16] = '{0, 1'b0, 12'h000, 12'h008, 12'h008, 12'h240, 12'h182, 12'h0BE};
    vt[17] = '{0, 1'b1, 12'h010, 12'h000, 12'h000, 12'h7FF, 12'h800, 12'h3F0};

    RST_n = 1'b0; start = 1'b0; clr = 1'b0; ch = 1'b0;
    kp = '0; ki = '0; kd = '0; sp = '0; mv = '0;
    repeat (3) @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);
    chk("reset busy",     32'(busy),     32'h0);
    chk("reset computed", 32'(computed), 32'h0);
    chk("reset response", 32'(response), 32'h0);
    chk("reset resp_ch",  32'(resp_ch),  32'h0);

    for (int k = 0; k < 18; k++) begin
      do_call(vt[k].clr_mode, vt[k].ch, vt[k].kp, vt[k].ki, vt[k].kd,
              vt[k].sp, vt[k].mv, r, rc, lat, b1, bd);
      chk($sformatf("vec%0d response", k), 32'(r),   32'(vt[k].exp_resp));
      chk($sformatf("vec%0d resp_ch", k),  32'(rc),  32'(vt[k].ch));
      chk($sformatf("vec%0d latency", k),  32'(lat), 32'd7);
      chk($sformatf("vec%0d busy", k),     32'(b1),  32'h1);
      chk($sformatf("vec%0d busy@done", k), 32'(bd), 32'h0);
    end

    // start and clr while busy are ignored: one pulse, state untouched
    ch = 1'b0; kp = 12'h000; ki = 12'h008; kd = 12'h000; sp = 12'h240; mv = 12'h182;
    start = 1'b1;
    @(posedge CLK); @(negedge CLK);
    kp = 12'h080; pulses = 0; cap = '0;
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (computed) pulses++;
      @(negedge CLK);
    end
    start = 1'b0; clr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (computed) begin pulses++; cap = response; end
      @(negedge CLK);
    end
    chk("busy-start pulses",   32'(pulses), 32'd1);
    chk("busy-start response", 32'(cap),    32'h100);
    do_call(0, 1'b0, 12'h000, 12'h008, 12'h000, 12'h240, 12'h182, r, rc, lat, b1, bd);
    chk("after busy-clr response", 32'(r), 32'h100);

    // reset asserted while the FSM is in MUL_I
    ch = 1'b0; kp = 12'h000; ki = 12'h008; kd = 12'h000; sp = 12'h240; mv = 12'h182;
    start = 1'b1;
    @(posedge CLK); @(negedge CLK);
    start = 1'b0;
    @(posedge CLK); @(negedge CLK);
    @(posedge CLK); @(negedge CLK);
    chk("busy in MUL_I", 32'(busy), 32'h1);
    RST_n = 1'b0;
    @(posedge CLK); @(negedge CLK);
    RST_n = 1'b1;
    chk("midreset busy",     32'(busy),     32'h0);
    chk("midreset computed", 32'(computed), 32'h0);
    chk("midreset response", 32'(response), 32'h0);
    chk("midreset resp_ch",  32'(resp_ch),  32'h0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (computed) pulses++;
      @(negedge CLK);
    end
    chk("midreset pulses", 32'(pulses), 32'd0);
    do_call(0, 1'b0, 12'h000, 12'h008, 12'h000, 12'h240, 12'h182, r, rc, lat, b1, bd);
    chk("post-reset ch0", 32'(r), 32'h05F);
    do_call(0, 1'b1, 12'h000, 12'h008, 12'h000, 12'h240, 12'h182, r, rc, lat, b1, bd);
    chk("post-reset ch1", 32'(r), 32'h05F);
    chk("post-reset ch1 id", 32'(rc), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
